// File: rtl/gpio_infilter_if.sv
// Pad-side and filtered-output bundle for the GPIO input filter.
interface gpio_infilter_if #(
    parameter int INNUM = 16
);
    logic [INNUM-1:0] pin_in;
    logic [7:0]       dflt_st;
    logic [7:0]       refclk_st;
    logic [INNUM-1:0] gpio_in;
    logic [INNUM-1:0] gpio_rise;
    logic [INNUM-1:0] gpio_fall;

    modport master (
        output pin_in,
        output dflt_st,
        output refclk_st,
        input  gpio_in,
        input  gpio_rise,
        input  gpio_fall
    );

    modport slave (
        input  pin_in,
        input  dflt_st,
        input  refclk_st,
        output gpio_in,
        output gpio_rise,
        output gpio_fall
    );
endinterface

// File: rtl/gpio_infilter.sv
// GPIO input synchronizer and per-bit glitch filter with shared sample prescaler.
module gpio_infilter #(
    parameter int INNUM = 16
) (
    input logic             clk,
    input logic             rst_n,
    gpio_infilter_if.slave  bus
);
    logic [INNUM-1:0] sync1_q, sync1_d;
    logic [INNUM-1:0] sync2_q, sync2_d;
    logic [INNUM-1:0] gpio_in_q, gpio_in_d;
    logic [INNUM-1:0] rise_q, rise_d;
    logic [INNUM-1:0] fall_q, fall_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic [7:0]       fcnt_q [INNUM];
    logic [7:0]       fcnt_d [INNUM];
    logic             tick;
    logic [8:0]       inc;

    always_comb begin
        sync1_d   = bus.pin_in;
        sync2_d   = sync1_q;
        gpio_in_d = gpio_in_q;
        fcnt_d    = fcnt_q;
        inc       = '0;
        // A lowered refclk_st below pcnt still ticks on the next cycle.
        tick      = (pcnt_q >= bus.refclk_st);
        pcnt_d    = tick ? 8'd0 : pcnt_q + 8'd1;

        if (bus.dflt_st == 8'd0) begin
            gpio_in_d = sync2_q;
            for (int i = 0; i < INNUM; i++) begin
                fcnt_d[i] = 8'd0;
            end
        end else if (tick) begin
            for (int i = 0; i < INNUM; i++) begin
                inc = {1'b0, fcnt_q[i]} + 9'd1;
                if (sync2_q[i] == gpio_in_q[i]) begin
                    fcnt_d[i] = 8'd0;
                end else if (inc >= {1'b0, bus.dflt_st}) begin
                    gpio_in_d[i] = sync2_q[i];
                    fcnt_d[i]    = 8'd0;
                end else if (fcnt_q[i] != 8'hFF) begin
                    fcnt_d[i] = inc[7:0];
                end
            end
        end

        rise_d = gpio_in_d & ~gpio_in_q;
        fall_d = ~gpio_in_d & gpio_in_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            gpio_in_q <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            pcnt_q    <= '0;
            for (int i = 0; i < INNUM; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            gpio_in_q <= gpio_in_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pcnt_q    <= pcnt_d;
            for (int i = 0; i < INNUM; i++) begin
                fcnt_q[i] <= fcnt_d[i];
            end
        end
    end

    assign bus.gpio_in   = gpio_in_q;
    assign bus.gpio_rise = rise_q;
    assign bus.gpio_fall = fall_q;
endmodule

// File: tb/tb_gpio_infilter.sv
// Vector-table and scoreboard bench for gpio_infilter.
module tb_gpio_infilter;
    typedef struct {
        logic        rst_n;
        logic [15:0] pin;
        logic [7:0]  dflt;
        logic [7:0]  refc;
        logic [15:0] ein;
        logic [15:0] erise;
        logic [15:0] efall;
    } vec_t;

    typedef struct {
        logic [15:0] ein;
        logic [15:0] erise;
        logic [15:0] efall;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail = 0;
    int   step_no = 0;
    vec_t tbl[$];
    exp_t sb[$];

    gpio_infilter_if #(.INNUM(16)) bus ();

    gpio_infilter #(.INNUM(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [15:0] pin,
                       input logic [7:0] dflt, input logic [7:0] refc,
                       input logic [15:0] ein, input logic [15:0] er,
                       input logic [15:0] ef);
        vec_t v;
        v.rst_n = r;
        v.pin   = pin;
        v.dflt  = dflt;
        v.refc  = refc;
        v.ein   = ein;
        v.erise = er;
        v.efall = ef;
        tbl.push_back(v);
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        rst_n         = v.rst_n;
        bus.pin_in    = v.pin;
        bus.dflt_st   = v.dflt;
        bus.refclk_st = v.refc;
        e.ein   = v.ein;
        e.erise = v.erise;
        e.efall = v.efall;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        n_tests++;
        step_no++;
        if (bus.gpio_in !== got.ein || bus.gpio_rise !== got.erise ||
            bus.gpio_fall !== got.efall) begin
            n_fail++;
            $display("FAIL step%0d: in=%h rise=%h fall=%h, expected in=%h rise=%h fall=%h",
                     step_no, bus.gpio_in, bus.gpio_rise, bus.gpio_fall,
                     got.ein, got.erise, got.efall);
        end
    endtask

    task automatic hstep(input logic r, input logic [15:0] pin,
                         input logic [7:0] dflt, input logic [15:0] ein,
                         input logic [15:0] er, input logic [15:0] ef);
        vec_t v;
        v.rst_n = r;
        v.pin   = pin;
        v.dflt  = dflt;
        v.refc  = 8'd0;
        v.ein   = ein;
        v.erise = er;
        v.efall = ef;
        step(v);
    endtask

    task automatic check_fcnt0(input string name, input logic [7:0] exp);
        n_tests++;
        if (dut.fcnt_q[0] !== exp) begin
            n_fail++;
            $display("FAIL %s: fcnt0=%0d expected %0d", name, dut.fcnt_q[0], exp);
        end
    endtask

    initial begin
        // Reset, then bypass: 3-edge latency and one-cycle pulses.
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add(0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'h0001, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'h0001, 0, 0, 16'h0001, 16'h0001, 16'h0000);
        add(1, 16'h0001, 0, 0, 16'h0001, 16'h0000, 16'h0000);
        add(1, 16'h0000, 0, 0, 16'h0001, 16'h0000, 16'h0000);
        add(1, 16'h0000, 0, 0, 16'h0001, 16'h0000, 16'h0000);
        add(1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0001);
        add(1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'hF00F, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'hF00F, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'hF00F, 0, 0, 16'hF00F, 16'hF00F, 16'h0000);
        add(1, 16'h0FF0, 0, 0, 16'hF00F, 16'h0000, 16'h0000);
        add(1, 16'h0FF0, 0, 0, 16'hF00F, 16'h0000, 16'h0000);
        add(1, 16'h0FF0, 0, 0, 16'h0FF0, 16'h0FF0, 16'hF00F);
        add(1, 16'h0000, 0, 0, 16'h0FF0, 16'h0000, 16'h0000);
        add(1, 16'h0000, 0, 0, 16'h0FF0, 16'h0000, 16'h0000);
        add(1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0FF0);
        add(1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        // Filter dflt=3: rise after edge 5, then fall after 5 more.
        add(1, 16'h0001, 3, 0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'h0001, 3, 0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'h0001, 3, 0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'h0001, 3, 0, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'h0001, 3, 0, 16'h0001, 16'h0001, 16'h0000);
        add(1, 16'h0001, 3, 0, 16'h0001, 16'h0000, 16'h0000);
        add(1, 16'h0000, 3, 0, 16'h0001, 16'h0000, 16'h0000);
        add(1, 16'h0000, 3, 0, 16'h0001, 16'h0000, 16'h0000);
        add(1, 16'h0000, 3, 0, 16'h0001, 16'h0000, 16'h0000);
        add(1, 16'h0000, 3, 0, 16'h0001, 16'h0000, 16'h0000);
        add(1, 16'h0000, 3, 0, 16'h0000, 16'h0000, 16'h0001);
        add(1, 16'h0000, 3, 0, 16'h0000, 16'h0000, 16'h0000);
        // Prescale refclk=3: reset aligns ticks to edges 4, 8, 12.
        add(0, 16'h0020, 0, 3, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'h0020, 0, 3, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'h0020, 0, 3, 16'h0000, 16'h0000, 16'h0000);
        add(1, 16'h0020, 0, 3, 16'h0020, 16'h0020, 16'h0000);
        add(1, 16'h0020, 0, 3, 16'h0020, 16'h0000, 16'h0000);
        for (int k = 5; k <= 11; k++) begin
            add(1, 16'h0000, 2, 3, 16'h0020, 16'h0000, 16'h0000);
        end
        add(1, 16'h0000, 2, 3, 16'h0000, 16'h0000, 16'h0020);
        add(1, 16'h0000, 2, 3, 16'h0000, 16'h0000, 16'h0000);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
        end

        // Glitch: two high samples never reach dflt=3.
        hstep(1, 16'h0001, 3, 16'h0000, 16'h0000, 16'h0000);
        hstep(1, 16'h0001, 3, 16'h0000, 16'h0000, 16'h0000);
        hstep(1, 16'h0000, 3, 16'h0000, 16'h0000, 16'h0000);
        check_fcnt0("glitch_e3", 8'd1);
        hstep(1, 16'h0000, 3, 16'h0000, 16'h0000, 16'h0000);
        check_fcnt0("glitch_e4", 8'd2);
        hstep(1, 16'h0000, 3, 16'h0000, 16'h0000, 16'h0000);
        check_fcnt0("glitch_clr", 8'd0);
        hstep(1, 16'h0000, 3, 16'h0000, 16'h0000, 16'h0000);

        // Reset mid-count with dflt=4 discards the partial count.
        for (int k = 0; k < 4; k++) begin
            hstep(1, 16'h0001, 4, 16'h0000, 16'h0000, 16'h0000);
        end
        check_fcnt0("midcnt", 8'd2);
        hstep(0, 16'h0001, 4, 16'h0000, 16'h0000, 16'h0000);
        check_fcnt0("rst_clr", 8'd0);
        for (int k = 0; k < 5; k++) begin
            hstep(1, 16'h0001, 4, 16'h0000, 16'h0000, 16'h0000);
        end
        hstep(1, 16'h0001, 4, 16'h0001, 16'h0001, 16'h0000);
        hstep(1, 16'h0001, 4, 16'h0001, 16'h0000, 16'h0000);

        // Lowering dflt mid-count commits on the next tick.
        for (int k = 0; k < 4; k++) begin
            hstep(1, 16'h0000, 4, 16'h0001, 16'h0000, 16'h0000);
        end
        check_fcnt0("pre_lower", 8'd2);
        hstep(1, 16'h0000, 2, 16'h0000, 16'h0000, 16'h0001);
        hstep(1, 16'h0000, 2, 16'h0000, 16'h0000, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gpio_infilter.md
GPIO_INFILTER -- requirements
Module: gpio_infilter

Interface
REQ-001 SHALL have parameter INNUM, default 16: number of input pins (1..32).
REQ-002 SHALL have port clk, input, 1: global clock; the block uses only this clock.
REQ-003 SHALL have port rst_n, input, 1: global reset, synchronous, active-low.
REQ-004 SHALL have port pin_in, input, INNUM: raw GPIO pad inputs, asynchronous to clk.
REQ-005 SHALL have port dflt_st, input, 8: digital filter setting; 0 = bypass, 1..255 = required consecutive samples.
REQ-006 SHALL have port refclk_st, input, 8: sample prescaler setting; sample period = refclk_st+1 clk cycles.
REQ-007 SHALL have port gpio_in, output, INNUM: filtered input state, registered, consumed by the GPIO register block.
REQ-008 SHALL have port gpio_rise, output, INNUM: one-cycle pulse per bit on a 0->1 change of gpio_in.
REQ-009 SHALL have port gpio_fall, output, INNUM: one-cycle pulse per bit on a 1->0 change of gpio_in.

Function
REQ-010 SHALL pass each pin_in bit through a 2-flop synchronizer (sync1 -> sync2) before any other use.
REQ-011 SHALL contain one shared 8-bit prescaler counter pcnt with tick = (pcnt >= refclk_st).
- On tick: pcnt clears to 0; otherwise pcnt increments by 1.
- refclk_st = 0 gives a tick every cycle.
- A lowered refclk_st below the current pcnt gives a tick on the next cycle.
REQ-012 SHALL, when dflt_st = 0 (bypass), load gpio_in <= sync2 every cycle, ignore tick, and hold all per-bit counters at 0.
- Latency: pin change to gpio_in = 3 clk edges.
REQ-013 SHALL, when dflt_st != 0, keep an 8-bit counter fcnt[i] per bit and update it only on tick:
- sync2[i] == gpio_in[i]: fcnt[i] <= 0.
- sync2[i] != gpio_in[i] and fcnt[i]+1 >= dflt_st: gpio_in[i] <= sync2[i] and fcnt[i] <= 0.
- Otherwise: fcnt[i] <= fcnt[i]+1; fcnt SHALL saturate and never wrap.
REQ-014 SHALL, with dflt_st reduced mid-count so that fcnt[i]+1 >= new dflt_st, update gpio_in[i] at the next tick with a differing sample.
REQ-015 SHALL hold gpio_in, fcnt and pcnt unchanged between ticks in filter mode.
REQ-016 SHALL assert gpio_rise[i] (gpio_fall[i]) for exactly one cycle: the first cycle gpio_in[i] shows the new value 1 (0).
REQ-017 SHALL never assert gpio_rise[i] and gpio_fall[i] in the same cycle.
REQ-018 SHALL filter all bits independently, each with its own fcnt, sharing the single tick.
REQ-019 SHALL apply a change of dflt_st between 0 and non-0 from the next clock edge, with no spurious edge pulse unless gpio_in actually changes.

Reset
REQ-020 SHALL, on any clk edge with rst_n = 0, set sync1, sync2, gpio_in, gpio_rise, gpio_fall, every fcnt and pcnt to 0, overriding all other activity including a tick.
REQ-021 SHALL resume normal operation on the first edge with rst_n = 1; a reset mid-count discards partial counts, with no pulse generated.

Verification
REQ-022 Bypass: dflt_st=0, refclk_st=0, pin_in[0] 0->1 before edge 1 -> gpio_in[0]=1 after edge 3; gpio_rise[0]=1 for that one cycle only.
REQ-023 Filter: dflt_st=3, refclk_st=0, pin_in[0] 0->1 held -> gpio_in[0]=1 after edge 5; gpio_rise[0] pulses once; other bits stay 0.
REQ-024 Glitch: dflt_st=3, refclk_st=0, pin_in[0] high for 2 cycles then low -> gpio_in[0] stays 0, no pulses, fcnt[0] returns to 0.
REQ-025 Prescale: dflt_st=2, refclk_st=3, pin_in[5] 1->0 held -> gpio_in[5] falls on the 2nd tick after sync2 changes (ticks 4 cycles apart); gpio_fall[5] pulses once.
REQ-026 Reset mid-count: dflt_st=4, fcnt[0]=2, rst_n=0 for one edge -> all outputs 0, fcnt[0]=0; with the pin still high, gpio_in[0] rises 6 edges after rst_n returns to 1.
